// File: rtl/mem_pkg.sv
// Shared encodings for the data-memory access unit: access sizes, FSM states,
// read-latency bounds and small size helpers.
package mem_pkg;

   localparam logic [1:0] MW_BYTE  = 2'b00;
   localparam logic [1:0] MW_HALF  = 2'b01;
   localparam logic [1:0] MW_WORD  = 2'b10;
   localparam logic [1:0] MW_DWORD = 2'b11;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      DONE    = 2'd2
   } memState_t;

   function automatic int accBytes(logic [1:0] w);
      return 1 << w;
   endfunction

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] sizeMask(logic [1:0] w);
      case (w)
         MW_BYTE: return 3'b000;
         MW_HALF: return 3'b001;
         MW_WORD: return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the pipeline (master) and the memory
// access unit (slave).
interface mem_access_unit_if #(
   parameter int DATA_W = 32
);
   logic              MemRead;
   logic              MemWrite;
   logic [1:0]        DataWidth;
   logic              SignExt;
   logic [31:0]       ALUResult;
   logic [DATA_W-1:0] ReadData2;
   logic [DATA_W-1:0] DataMem_out;
   logic              Valid;
   logic              Stall;
   logic              MisalignErr;

   modport master (
      output MemRead, MemWrite, DataWidth, SignExt, ALUResult, ReadData2,
      input  DataMem_out, Valid, Stall, MisalignErr
   );

   modport slave (
      input  MemRead, MemWrite, DataWidth, SignExt, ALUResult, ReadData2,
      output DataMem_out, Valid, Stall, MisalignErr
   );
endinterface

// File: rtl/dm_ram.sv
// Byte-enabled data RAM with an RD_LAT-deep read pipeline; contents are never
// reset.
module dm_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1,
   localparam int NB    = DATA_W / 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [NB-1:0]     be,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem    [DEPTH];
   logic [DATA_W-1:0] rdPipe [RD_LAT];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < NB; i++) begin
            if (be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
   end

   // Stage 0 samples the addressed word every cycle; later stages just age it.
   always_ff @(posedge clk) begin
      rdPipe[0] <= mem[addr];
      for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
   end

   assign rdata = rdPipe[RD_LAT-1];

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: validates requests, writes lanes into dm_ram, and returns
// extended load lanes after a fixed RD_LAT latency.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 1024,
   parameter int RD_LAT = 1
) (
   input  logic              Clk,
   input  logic              Reset,
   mem_access_unit_if.slave  bus
);

   localparam int NB   = DATA_W / 8;
   localparam int OFFW = $clog2(NB);
   localparam int AW   = $clog2(DEPTH);

   memState_t         state;
   logic [1:0]        cnt;
   logic [OFFW-1:0]   reqOff;
   logic [1:0]        reqWidth;
   logic              reqSign;
   logic [DATA_W-1:0] dataReg;
   logic              validQ;
   logic              errQ;

   logic              illegal, anyReq, isIdle, doStore, doLoad;
   logic [NB-1:0]     be;
   logic [DATA_W-1:0] wdata, ramRdata, lane, ext;
   logic [AW-1:0]     wordIdx;

   assign anyReq  = bus.MemRead | bus.MemWrite;
   assign illegal = (bus.MemRead & bus.MemWrite)
                  | ((bus.DataWidth == MW_DWORD) && (DATA_W == 32))
                  | ((bus.ALUResult[2:0] & sizeMask(bus.DataWidth)) != 3'b000);
   assign isIdle  = (state == IDLE);
   assign doStore = isIdle & bus.MemWrite & ~illegal & ~Reset;
   assign doLoad  = isIdle & bus.MemRead & ~illegal;
   assign wordIdx = bus.ALUResult[AW+OFFW-1:OFFW];

   always_comb begin
      be    = '0;
      wdata = '0;
      for (int i = 0; i < NB; i++) begin
         be[i] = (i >= int'(bus.ALUResult[OFFW-1:0]))
              && (i <  int'(bus.ALUResult[OFFW-1:0]) + accBytes(bus.DataWidth));
         case (bus.DataWidth)
            MW_BYTE: wdata[i*8 +: 8] = bus.ReadData2[7:0];
            MW_HALF: wdata[i*8 +: 8] = bus.ReadData2[(i%2)*8 +: 8];
            MW_WORD: wdata[i*8 +: 8] = bus.ReadData2[(i%4)*8 +: 8];
            default: wdata[i*8 +: 8] = bus.ReadData2[i*8 +: 8];
         endcase
      end
   end

   dm_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) uRam (
      .clk   (Clk),
      .we    (doStore),
      .be    (be),
      .addr  (wordIdx),
      .wdata (wdata),
      .rdata (ramRdata)
   );

   // Lane extraction uses the size/offset captured when the load was accepted.
   always_comb begin
      int   nBits;
      logic signBit;
      lane  = ramRdata >> {reqOff, 3'b000};
      nBits = accBytes(reqWidth) * 8;
      if (nBits > DATA_W) nBits = DATA_W;
      signBit = reqSign & lane[nBits-1];
      ext = lane;
      for (int i = 0; i < DATA_W; i++) begin
         if (i >= nBits) ext[i] = signBit;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state   <= IDLE;
         cnt     <= '0;
         dataReg <= '0;
         validQ  <= 1'b0;
         errQ    <= 1'b0;
      end else begin
         validQ <= 1'b0;
         errQ   <= 1'b0;
         case (state)
            IDLE: begin
               if (anyReq && illegal) begin
                  errQ <= 1'b1;
               end else if (doLoad) begin
                  reqOff   <= bus.ALUResult[OFFW-1:0];
                  reqWidth <= bus.DataWidth;
                  reqSign  <= bus.SignExt;
                  if (RD_LAT > 1) begin
                     state <= RD_WAIT;
                     cnt   <= 2'(RD_LAT - 2);
                  end else begin
                     state  <= DONE;
                     validQ <= 1'b1;
                  end
               end
            end
            RD_WAIT: begin
               if (cnt == 2'd0) begin
                  state  <= DONE;
                  validQ <= 1'b1;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
            DONE: begin
               dataReg <= ext;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.Valid       = validQ;
   assign bus.MisalignErr = errQ;
   assign bus.Stall       = doLoad | (state == RD_WAIT);
   assign bus.DataMem_out = (state == DONE) ? ext : dataReg;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, giving the data path width in bits; legal values are 32 and 64.
REQ-002 The block SHALL have the parameter DEPTH, default 1024, giving the number of DATA_W-bit words; it must be a power of two.
REQ-003 The block SHALL have the parameter RD_LAT, default 1, giving the RAM read latency in cycles; legal range is 1..4.
REQ-004 Clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 Reset  in  1  synchronous, active-high reset.
REQ-006 MemRead  in  1  load request.
REQ-007 MemWrite  in  1  store request.
REQ-008 DataWidth  in  2  access size: 00 byte, 01 half, 10 word(32), 11 dword (legal only when DATA_W=64).
REQ-009 SignExt  in  1  load result sign-extended (1) or zero-extended (0).
REQ-010 ALUResult  in  32  byte address.
REQ-011 ReadData2  in  DATA_W  store data; the access-size bits are taken from its LSBs.
REQ-012 DataMem_out  out  DATA_W  load result, registered.
REQ-013 Valid  out  1  single-cycle pulse marking DataMem_out valid.
REQ-014 Stall  out  1  holds the upstream pipeline.
REQ-015 MisalignErr  out  1  single-cycle error pulse.

Function
REQ-016 The block SHALL implement a state machine with states IDLE, RD_WAIT and DONE.
REQ-017 Requests SHALL be sampled only in IDLE; inputs in RD_WAIT and DONE SHALL be ignored.
REQ-018 A request SHALL be flagged illegal, and treated as an error, in any of these cases:
- MemRead and MemWrite both high;
- DataWidth=11 with DATA_W=32;
- the address is not naturally aligned to the access size.
REQ-019 An illegal request in IDLE SHALL cause no RAM access and SHALL pulse MisalignErr one cycle later with Stall low; the state SHALL remain IDLE.
REQ-020 A legal store in IDLE SHALL write the RAM at that edge with byte enables selected by the address low bits, with the data replicated into the selected lane, with Stall low and with no state change.
REQ-021 A legal load in IDLE SHALL drive Stall high in the request cycle combinationally.
REQ-022 After the load is accepted, the state SHALL move to RD_WAIT when RD_LAT>1, otherwise to DONE.
REQ-023 RD_WAIT SHALL count down RD_LAT-1 cycles with Stall high, then move to DONE.
REQ-024 In DONE, the block SHALL drive Valid=1, Stall=0 and DataMem_out equal to the extracted lane (sign- or zero-extended to DATA_W), then return to IDLE.
REQ-025 Load latency SHALL be exactly RD_LAT cycles from the request edge to the Valid cycle.
REQ-026 The word index SHALL be ALUResult[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]; higher address bits SHALL be ignored, so addresses wrap modulo DEPTH words.
REQ-027 DataMem_out SHALL hold its last loaded value outside DONE.
REQ-028 Valid and MisalignErr SHALL be low in all other cycles.
REQ-029 A store and a load to the same address in consecutive IDLE cycles SHALL return the new data.

Reset
REQ-030 When Reset is high at an edge, the block SHALL force the state to IDLE and set DataMem_out=0, Valid=0, MisalignErr=0 and the latency counter to 0.
REQ-031 Stall SHALL be 0 in the cycle after a reset edge.
REQ-032 Reset asserted in the same cycle as a store SHALL suppress the write.
REQ-033 Reset during RD_WAIT or DONE SHALL abort the load with no Valid pulse.
REQ-034 Reset SHALL leave RAM contents unchanged (no clear).

Structure
REQ-035 The package mem_pkg SHALL hold:
- the DataWidth encodings (MW_BYTE, MW_HALF, MW_WORD, MW_DWORD);
- the state enum;
- the RD_LAT bounds.
REQ-036 A sub-module dm_ram SHALL hold the storage: byte-enabled write, read pipeline of RD_LAT registers, no reset.
REQ-037 Lane extraction, extension and alignment checks SHALL be combinational logic in mem_access_unit.

Verification
REQ-038 The bench SHALL cover these directed scenarios (DATA_W=32, RD_LAT=2):
- Byte/sign load: store word 0x80FF7F01 at 0x10; load byte with SignExt=1 at 0x13 -> DataMem_out=0xFFFFFF80, Valid exactly 2 cycles after request, Stall high 2 cycles.
- Half/zero load: same data, load half with SignExt=0 at 0x12 -> 0x000080FF.
- Misaligned half: half load at 0x11 -> MisalignErr pulse, no Valid, Stall low, RAM unchanged.
- Both requests high: MemRead=MemWrite=1 at 0x20 -> MisalignErr pulse, word at 0x20 unchanged.
- Address wrap: DEPTH=1024; word store 0xDEADBEEF at 0x1000 -> word load at 0x0 returns 0xDEADBEEF.
- Reset mid-load: Reset high one cycle after a load request -> no Valid, next cycle Stall=0 and state IDLE.
